complex_div_seq: RTL

COMPLEX_DIV_SEQ -- requirements
Module: complex_div_seq

---
 rtl/complex_div_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/complex_div_seq.sv
// Sequential complex divider on signed Q4.4 operands: one multiply cycle, then a
// 20-cycle restoring divide computing both quotient parts in parallel, with saturation.
module complex_div_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] aj,
  input  logic [7:0] b,
  input  logic [7:0] bj,
  output logic [7:0] c,
  output logic [7:0] cj,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic       div_zero
);

  // state | meaning
  // IDLE  | waiting for start, operands not yet captured
  // MUL   | form numerators and denominator from captured operands
  // DIV   | 20 restoring shift-subtract steps, both parts in parallel
  // DONE  | results valid, done pulse high
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic signed [7:0]  a_r, aj_r, b_r, bj_r;
  logic [15:0]        den;
  logic [19:0]        dvd_re, dvd_im;
  logic [18:0]        quo_re, quo_im;
  logic [15:0]        rem_re, rem_im;
  logic               neg_re, neg_im;
  logic [4:0]         cnt;

  logic signed [15:0] p_ab, p_ajbj, p_ajb, p_abj, p_bb, p_bjbj;
  logic signed [16:0] num_re_c, num_im_c;
  logic [15:0]        den_c;
  logic [16:0]        sh_re, sh_im;
  logic               ge_re, ge_im;
  logic [15:0]        rem_nx_re, rem_nx_im;
  logic [19:0]        quo_nx_re, quo_nx_im;
  logic [8:0]         sat_re, sat_im;

  function automatic logic [15:0] mag(input logic signed [16:0] x);
    return x[16] ? 16'(-x) : 16'(x);
  endfunction

  // Returns {saturated, value}; a negative magnitude of exactly 128 is representable.
  function automatic logic [8:0] sat(input logic [19:0] q, input logic neg);
    logic [7:0] nq;
    nq = ~q[7:0] + 8'd1;
    if (!neg) return (q > 20'd127) ? 9'h17F : {1'b0, q[7:0]};
    return (q > 20'd128) ? 9'h180 : {1'b0, nq};
  endfunction

  assign p_ab   = a_r * b_r;
  assign p_ajbj = aj_r * bj_r;
  assign p_ajb  = aj_r * b_r;
  assign p_abj  = a_r * bj_r;
  assign p_bb   = b_r * b_r;
  assign p_bjbj = bj_r * bj_r;

  assign num_re_c = $signed({p_ab[15], p_ab}) + $signed({p_ajbj[15], p_ajbj});
  assign num_im_c = $signed({p_ajb[15], p_ajb}) - $signed({p_abj[15], p_abj});
  assign den_c    = $unsigned(p_bb) + $unsigned(p_bjbj);

  // Remainder stays below den (<= 32768), so 16 bits hold it between steps.
  always_comb begin
    sh_re     = {rem_re, dvd_re[19]};
    sh_im     = {rem_im, dvd_im[19]};
    ge_re     = sh_re >= {1'b0, den};
    ge_im     = sh_im >= {1'b0, den};
    rem_nx_re = ge_re ? 16'(sh_re - {1'b0, den}) : sh_re[15:0];
    rem_nx_im = ge_im ? 16'(sh_im - {1'b0, den}) : sh_im[15:0];
    quo_nx_re = {quo_re, ge_re};
    quo_nx_im = {quo_im, ge_im};
    sat_re    = sat(quo_nx_re, neg_re);
    sat_im    = sat(quo_nx_im, neg_im);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      c        <= 8'h00;
      cj       <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      div_zero <= 1'b0;
      a_r      <= 8'sd0;
      aj_r     <= 8'sd0;
      b_r      <= 8'sd0;
      bj_r     <= 8'sd0;
      den      <= 16'd0;
      dvd_re   <= 20'd0;
      dvd_im   <= 20'd0;
      quo_re   <= 19'd0;
      quo_im   <= 19'd0;
      rem_re   <= 16'd0;
      rem_im   <= 16'd0;
      neg_re   <= 1'b0;
      neg_im   <= 1'b0;
      cnt      <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            aj_r  <= aj;
            b_r   <= b;
            bj_r  <= bj;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          den    <= den_c;
          dvd_re <= {mag(num_re_c), 4'b0000};
          dvd_im <= {mag(num_im_c), 4'b0000};
          neg_re <= num_re_c[16];
          neg_im <= num_im_c[16];
          rem_re <= 16'd0;
          rem_im <= 16'd0;
          quo_re <= 19'd0;
          quo_im <= 19'd0;
          cnt    <= 5'd0;
          if (den_c == 16'd0) begin
            c        <= 8'h00;
            cj       <= 8'h00;
            ovf      <= 1'b0;
            div_zero <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          dvd_re <= {dvd_re[18:0], 1'b0};
          dvd_im <= {dvd_im[18:0], 1'b0};
          rem_re <= rem_nx_re;
          rem_im <= rem_nx_im;
          quo_re <= quo_nx_re[18:0];
          quo_im <= quo_nx_im[18:0];
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd19) begin
            c        <= sat_re[7:0];
            cj       <= sat_im[7:0];
            ovf      <= sat_re[8] | sat_im[8];
            div_zero <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
